// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage.
// Build option: OPERAND_FETCH_ZERO_REG_EN hardwires register index 0 to zero.
package operand_fetch_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned IDX_W_DEF  = 5;
    localparam int unsigned TAG_W_DEF  = 32;
    localparam int unsigned ZERO_IDX   = 0;

`ifdef OPERAND_FETCH_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    // A valid/ready transfer happens when both sides agree in the same cycle.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_slot.sv
// Per-operand forwarding slot: captures a regfile write aimed at the tracked
// index and selects between the captured value and the regfile read data.
// Build option: OPERAND_FETCH_ZERO_REG_EN (via package) gates index 0 to zero.
module operand_fwd_slot
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [IDX_W-1:0]  cap_idx,
    input  logic [IDX_W-1:0]  held_idx,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_windex,
    input  logic [DATA_W-1:0] wb_win,
    input  logic [DATA_W-1:0] rf_rout,
    output logic [DATA_W-1:0] val
);

    logic              fv_q, fv_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic              hit;

    // Capture a write to the index being read this edge; the regfile's
    // read-before-write ordering would otherwise return the stale value.
    always_comb begin
        hit  = wb_we && (wb_windex == cap_idx);
        if (ZERO_REG_EN && (cap_idx == IDX_W'(ZERO_IDX))) begin
            hit = 1'b0;
        end
        fv_d = clear ? 1'b0 : hit;
        fd_d = clear ? fd_q : wb_win;
    end

    // Forward slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q <= 1'b0;
            fd_q <= '0;
        end else begin
            fv_q <= fv_d;
            fd_q <= fd_d;
        end
    end

    // Operand select: forwarded data wins over the regfile read.
    always_comb begin
        val = fv_q ? fd_q : rf_rout;
        if (ZERO_REG_EN && (held_idx == IDX_W'(ZERO_IDX))) begin
            val = '0;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: issues regfile reads for a
// (rs, rt, tag) request and presents both operands one cycle later, forwarding
// regfile writes that the registered read port would miss.
// Build option: OPERAND_FETCH_ZERO_REG_EN hardwires register index 0 to zero.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_rs,
    input  logic [IDX_W-1:0]  in_rt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [IDX_W-1:0]  rf_rindex0,
    output logic [IDX_W-1:0]  rf_rindex1,
    input  logic [DATA_W-1:0] rf_rout0,
    input  logic [DATA_W-1:0] rf_rout1,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_windex,
    input  logic [DATA_W-1:0] wb_win,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [TAG_W-1:0]  out_tag
);

    logic              v_q, v_d;
    logic [IDX_W-1:0]  h_rs_q, h_rs_d;
    logic [IDX_W-1:0]  h_rt_q, h_rt_d;
    logic [TAG_W-1:0]  h_tag_q, h_tag_d;
    logic              accept, out_fire, slot_clear;
    logic [IDX_W-1:0]  cap_rs, cap_rt;

    // Handshake and read-index steering; a stall re-reads the held indices.
    always_comb begin
        in_ready   = !v_q || out_ready;
        accept     = hs_fire(in_valid, in_ready);
        out_fire   = hs_fire(v_q, out_ready);
        slot_clear = !accept && out_fire;
        cap_rs     = accept ? in_rs : h_rs_q;
        cap_rt     = accept ? in_rt : h_rt_q;
        rf_rindex0 = in_ready ? in_rs : h_rs_q;
        rf_rindex1 = in_ready ? in_rt : h_rt_q;
    end

    // Holding register next state: accept beats drain, otherwise hold.
    always_comb begin
        v_d     = v_q;
        h_rs_d  = h_rs_q;
        h_rt_d  = h_rt_q;
        h_tag_d = h_tag_q;
        if (accept) begin
            v_d     = 1'b1;
            h_rs_d  = in_rs;
            h_rt_d  = in_rt;
            h_tag_d = in_tag;
        end else if (out_fire) begin
            v_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= 1'b0;
            h_rs_q  <= '0;
            h_rt_q  <= '0;
            h_tag_q <= '0;
        end else begin
            v_q     <= v_d;
            h_rs_q  <= h_rs_d;
            h_rt_q  <= h_rt_d;
            h_tag_q <= h_tag_d;
        end
    end

    assign out_valid = v_q;
    assign out_tag   = h_tag_q;

    operand_fwd_slot #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_slot_rs (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (slot_clear),
        .cap_idx   (cap_rs),
        .held_idx  (h_rs_q),
        .wb_we     (wb_we),
        .wb_windex (wb_windex),
        .wb_win    (wb_win),
        .rf_rout   (rf_rout0),
        .val       (out_rs_val)
    );

    operand_fwd_slot #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_slot_rt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (slot_clear),
        .cap_idx   (cap_rt),
        .held_idx  (h_rt_q),
        .wb_we     (wb_we),
        .wb_windex (wb_windex),
        .wb_win    (wb_win),
        .rf_rout   (rf_rout1),
        .val       (out_rt_val)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural regfile drives the read port, accepted
// requests are queued, and a monitor compares every valid output against the
// architectural register contents (writes applied at each edge).
module tb_operand_fetch;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 5;
    localparam int unsigned TW = 32;

`ifdef OPERAND_FETCH_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [IW-1:0] in_rs, in_rt;
    logic [TW-1:0] in_tag;
    logic [IW-1:0] rf_rindex0, rf_rindex1;
    logic [DW-1:0] rf_rout0, rf_rout1;
    logic          wb_we;
    logic [IW-1:0] wb_windex;
    logic [DW-1:0] wb_win;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rs_val, out_rt_val;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    operand_fetch #(
        .DATA_W (DW),
        .IDX_W  (IW),
        .TAG_W  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_tag     (in_tag),
        .rf_rindex0 (rf_rindex0),
        .rf_rindex1 (rf_rindex1),
        .rf_rout0   (rf_rout0),
        .rf_rout1   (rf_rout1),
        .wb_we      (wb_we),
        .wb_windex  (wb_windex),
        .wb_win     (wb_win),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rs_val (out_rs_val),
        .out_rt_val (out_rt_val),
        .out_tag    (out_tag)
    );

    // Behavioural 2R/1W regfile with registered, read-before-write outputs.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        rf_rout0 <= mem[rf_rindex0];
        rf_rout1 <= mem[rf_rindex1];
        if (wb_we) mem[wb_windex] <= wb_win;
    end

    typedef struct {
        logic [IW-1:0] rs;
        logic [IW-1:0] rt;
        logic [TW-1:0] tag;
    } req_t;

    req_t sb_q[$];
    req_t mon_r;
    int   errors = 0;
    int   checks = 0;
    int   acc_count = 0;
    int   fire_count = 0;
    bit   rand_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value of a register as of the current cycle.
    function automatic logic [DW-1:0] exp_val(input logic [IW-1:0] idx);
        if (ZERO_EN && idx == '0) return '0;
        return mem[idx];
    endfunction

    // Scoreboard push on every accepted request.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back('{rs: in_rs, rt: in_rt, tag: in_tag});
            acc_count++;
        end
    end

    // Monitor: compare presented outputs with the queue head and the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || out_ready));
            chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            if (out_valid && sb_q.size() != 0) begin
                mon_r = sb_q[0];
                chk("out_tag", out_tag, mon_r.tag);
                chk("out_rs_val", out_rs_val, exp_val(mon_r.rs));
                chk("out_rt_val", out_rt_val, exp_val(mon_r.rt));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    fire_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_on) begin
            wb_we     = ($urandom_range(0, 1) == 1);
            wb_windex = IW'($urandom_range(0, 7));
            wb_win    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic issue(input logic [IW-1:0] rs, input logic [IW-1:0] rt,
                         input logic [TW-1:0] tag, output int waited);
        int start;
        start    = acc_count;
        in_valid = 1'b1;
        in_rs    = rs;
        in_rt    = rt;
        in_tag   = tag;
        waited   = 0;
        do begin
            tick();
            waited++;
        end while (acc_count == start && waited < 50);
        if (acc_count == start) chk("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    int w, total;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rs     = '0;
        in_rt     = '0;
        in_tag    = '0;
        wb_we     = 1'b0;
        wb_windex = '0;
        wb_win    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3] = 32'h11;
        mem[4] = 32'h22;

        #12;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read.
        issue(5'd3, 5'd4, 32'hA0, w);
        chk("t1_valid", 32'(out_valid), 32'(1));
        chk("t1_rs", out_rs_val, 32'h11);
        chk("t1_rt", out_rt_val, 32'h22);
        chk("t1_tag", out_tag, 32'hA0);
        tick();

        // Same-edge write and accept on the same index.
        wb_we = 1'b1; wb_windex = 5'd5; wb_win = 32'hDEAD;
        issue(5'd5, 5'd3, 32'hB0, w);
        wb_we = 1'b0;
        chk("t2_fwd_rs", out_rs_val, 32'hDEAD);
        chk("t2_rt", out_rt_val, 32'h11);
        tick();

        // Stall with a write to the held rt in stall cycle 2.
        out_ready = 1'b0;
        issue(5'd1, 5'd4, 32'hC0, w);
        tick();
        wb_we = 1'b1; wb_windex = 5'd4; wb_win = 32'h99;
        tick();
        wb_we = 1'b0;
        chk("t3_fwd_rt", out_rt_val, 32'h99);
        chk("t3_stall_in_ready", 32'(in_ready), 32'(0));
        tick();
        chk("t3_reread_rt", out_rt_val, 32'h99);
        chk("t3_tag_stable", out_tag, 32'hC0);
        out_ready = 1'b1;
        tick();

        // Back-to-back stream of 8.
        total = 0;
        begin
            int start_fire;
            start_fire = fire_count;
            for (int i = 0; i < 8; i++) begin
                issue(IW'(i), IW'(i + 1), TW'(32'h100 + i), w);
                total += w;
            end
            chk("t4_accept_cycles", 32'(total), 32'(8));
            @(negedge clk);
            #1;
            chk("t4_results", 32'(fire_count - start_fire), 32'(8));
        end
        tick();

        // Index 0 behaviour.
        wb_we = 1'b1; wb_windex = 5'd0; wb_win = 32'h55;
        tick();
        wb_we = 1'b0;
        tick();
        issue(5'd0, 5'd0, 32'hD0, w);
        chk("t5_zero_rs", out_rs_val, ZERO_EN ? 32'h0 : 32'h55);
        chk("t5_zero_rt", out_rt_val, ZERO_EN ? 32'h0 : 32'h55);
        tick();

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        issue(5'd2, 5'd3, 32'hE0, w);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 32'(out_valid), 32'(0));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(5'd3, 5'd4, 32'hF0, w);
        chk("t6_post_rs", out_rs_val, 32'h11);
        chk("t6_post_rt", out_rt_val, 32'h99);
        chk("t6_post_tag", out_tag, 32'hF0);
        tick();

        // Randomised traffic with writes and backpressure.
        rand_on = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7)), $urandom, w);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        rand_on   = 1'b0;
        wb_we     = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 20 && sb_q.size() != 0; d++) tick();
        chk("drain_empty", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
